// File: rtl/mux_rr_pkg.sv
// Shared types and sizes for the round-robin selector sequencer.
// Imported by the interface, the pick logic and the top level.
package mux_rr_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] onehot(
    input logic [SEL_W-1:0] i
  );
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_sequencer_if.sv
// Request/selector bundle between requesters and the sequencer.
// master = sequencer side, slave = requester/selector side.
interface mux_rr_sequencer_if;
  import mux_rr_pkg::*;

  logic [NREQ-1:0]  REQ;
  logic             G;
  logic [SEL_W-1:0] C;
  logic [NREQ-1:0]  GNT;
  logic             BUSY;

  modport master (
    input  REQ,
    output G,
    output C,
    output GNT,
    output BUSY
  );

  modport slave (
    output REQ,
    input  G,
    input  C,
    input  GNT,
    input  BUSY
  );

endinterface

// File: rtl/rr_pick4.sv
// Rotating-priority pick over four requests.
// First set request found starting from ptr, wrapping mod 4.
module rr_pick4
  import mux_rr_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             valid
);

  logic             found;
  logic [SEL_W-1:0] cand;

  // scan ptr, ptr+1, ... and keep the first hit
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/mux_rr_sequencer.sv
// Round-robin owner of a shared 4:1 selector (G low-active, C select).
// Grant changes are break-before-make through a one-cycle GAP.
module mux_rr_sequencer
  import mux_rr_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input logic CLK,
  input logic RST,
  mux_rr_sequencer_if.master bus
);

  localparam int CNT_W =
    (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(HOLD_MAX - 1);
  localparam bit HOLD_ON = (HOLD_MAX != 0);

  state_t           state, state_nx;
  logic [SEL_W-1:0] ptr, ptr_nx;
  logic [SEL_W-1:0] c_q, c_nx;
  logic             g_q, g_nx;
  logic [NREQ-1:0]  gnt_q, gnt_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_valid;
  logic             owner_req;
  logic             others;
  logic             timeout;
  logic [CNT_W-1:0] cnt_sat;

  rr_pick4 u_pick (
    .req   (bus.REQ),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign owner_req = bus.REQ[c_q];
  assign others    = |(bus.REQ & ~onehot(c_q));
  assign timeout   = HOLD_ON
                   && (cnt == CNT_LAST)
                   && others;
  assign cnt_sat   = (cnt == CNT_MAX)
                   ? cnt
                   : cnt + 1'b1;

  // next state, next pointer and next selector outputs
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    c_nx     = c_q;
    g_nx     = g_q;
    gnt_nx   = gnt_q;
    cnt_nx   = cnt;
    unique case (state)
      IDLE, GAP: begin
        if (pick_valid) begin
          state_nx = GRANT;
          c_nx     = pick_idx;
          g_nx     = 1'b0;
          gnt_nx   = onehot(pick_idx);
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      GRANT: begin
        cnt_nx = cnt_sat;
        if (!owner_req || timeout) begin
          state_nx = GAP;
          g_nx     = 1'b1;
          gnt_nx   = '0;
          ptr_nx   = c_q + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        g_nx     = 1'b1;
        gnt_nx   = '0;
      end
    endcase
  end

  // state and registered selector drive, cleared at once on reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      c_q   <= '0;
      g_q   <= 1'b1;
      gnt_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      c_q   <= c_nx;
      g_q   <= g_nx;
      gnt_q <= gnt_nx;
      cnt   <= cnt_nx;
    end
  end

  assign bus.G    = g_q;
  assign bus.C    = c_q;
  assign bus.GNT  = gnt_q;
  assign bus.BUSY = (state != IDLE);

endmodule

// File: tb/tb_mux_rr_sequencer.sv
// Directed bench for mux_rr_sequencer.
// Two instances: hold limit 4 and unlimited hold.
module tb_mux_rr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mux_rr_sequencer_if bus4 ();
  mux_rr_sequencer_if bus0 ();

  mux_rr_sequencer #(.HOLD_MAX(4)) u4 (
    .CLK (clk),
    .RST (rst),
    .bus (bus4)
  );

  mux_rr_sequencer #(.HOLD_MAX(0)) u0 (
    .CLK (clk),
    .RST (rst),
    .bus (bus0)
  );

  logic [7:0] o4, o0;
  assign o4 = {bus4.G, bus4.C, bus4.GNT, bus4.BUSY};
  assign o0 = {bus0.G, bus0.C, bus0.GNT, bus0.BUSY};

  function automatic logic [7:0] e_grant(input logic [1:0] i);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    return {1'b0, i, oh, 1'b1};
  endfunction

  function automatic logic [7:0] e_gap(input logic [1:0] i);
    return {1'b1, i, 4'b0000, 1'b1};
  endfunction

  function automatic logic [7:0] e_idle(input logic [1:0] i);
    return {1'b1, i, 4'b0000, 1'b0};
  endfunction

  task automatic check(
    input string      tag,
    input logic [7:0] o,
    input logic [7:0] e
  );
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b (G,C,GNT,BUSY)",
             tag, o, e);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] own;
    bus4.REQ = 4'b0000;
    bus0.REQ = 4'b0000;

    // reset state
    #2 rst = 1'b1;
    #1 check("rst4", o4, e_idle(2'd0));
    check("rst0", o0, e_idle(2'd0));
    step;
    step;
    rst = 1'b0;

    // single request, one-cycle latency, drop -> gap -> idle
    bus4.REQ = 4'b0100;
    step;
    check("t1_grant", o4, e_grant(2'd2));
    bus4.REQ = 4'b0000;
    step;
    check("t1_gap", o4, e_gap(2'd2));
    step;
    check("t1_idle", o4, e_idle(2'd2));

    // fresh reset so ptr=0, then all four request
    #2 rst = 1'b1;
    #1 check("t2_rst", o4, e_idle(2'd0));
    step;
    rst = 1'b0;
    bus4.REQ = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      own = 2'(n);
      for (int c = 0; c < 4; c++) begin
        step;
        check($sformatf("t2_grant%0d_c%0d", n, c),
              o4, e_grant(own));
      end
      step;
      check($sformatf("t2_gap%0d", n), o4, e_gap(own));
    end
    bus4.REQ = 4'b0000;
    step;
    check("t2_idle", o4, e_idle(2'd0));

    // lone requester never times out (ptr=1)
    bus4.REQ = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      step;
      check($sformatf("t3_hold_c%0d", c), o4, e_grant(2'd1));
    end
    bus4.REQ = 4'b0000;
    step;
    check("t3_gap", o4, e_gap(2'd1));
    step;
    check("t3_idle", o4, e_idle(2'd1));

    // timeout on 3 with 0 waiting, then wrap to 1 (ptr=2)
    bus4.REQ = 4'b1000;
    step;
    check("t4_g3_c0", o4, e_grant(2'd3));
    bus4.REQ = 4'b1001;
    for (int c = 1; c < 4; c++) begin
      step;
      check($sformatf("t4_g3_c%0d", c), o4, e_grant(2'd3));
    end
    step;
    check("t4_gap3", o4, e_gap(2'd3));
    step;
    check("t4_g0", o4, e_grant(2'd0));
    bus4.REQ = 4'b1010;
    step;
    check("t4_gap0", o4, e_gap(2'd0));
    step;
    check("t4_g1", o4, e_grant(2'd1));
    bus4.REQ = 4'b0000;
    step;
    check("t4_gap1", o4, e_gap(2'd1));
    step;
    check("t4_idle", o4, e_idle(2'd1));

    // asynchronous reset in the middle of a grant (ptr=2)
    bus4.REQ = 4'b0100;
    step;
    check("t5_grant", o4, e_grant(2'd2));
    #2 rst = 1'b1;
    #1 check("t5_async", o4, e_idle(2'd0));
    bus4.REQ = 4'b0001;
    step;
    rst = 1'b0;
    step;
    check("t5_regrant", o4, e_grant(2'd0));
    bus4.REQ = 4'b0000;
    step;
    check("t5_gap", o4, e_gap(2'd0));
    step;
    check("t5_idle", o4, e_idle(2'd0));

    // unlimited hold with a competitor waiting
    bus0.REQ = 4'b0011;
    for (int c = 0; c < 50; c++) begin
      step;
      check($sformatf("t6_hold_c%0d", c), o0, e_grant(2'd0));
    end
    bus0.REQ = 4'b0000;
    step;
    check("t6_gap", o0, e_gap(2'd0));
    step;
    check("t6_idle", o0, e_idle(2'd0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
